// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared FSM encoding and counter width helpers for the layer sequencer
package layer_seq_pkg;
  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int NUM_INPUTS_DEF = 784;
  localparam int NUM_NEURONS_DEF = 30;
  localparam int IN_CNT_W = cnt_w(NUM_INPUTS_DEF);
  localparam int NRN_CNT_W = cnt_w(NUM_NEURONS_DEF);
endpackage

// File: rtl/layer_capture_bank.sv
// layer_capture_bank: per-neuron result capture, done mask, duplicate detection and read mux
module layer_capture_bank
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATAWIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]           nrn_out_valid,
  input  logic                             clr,
  input  logic [cnt_w(NUM_NEURONS)-1:0]    rd_idx,
  output logic [DATAWIDTH-1:0]             rd_data,
  output logic                             all_done,
  output logic                             dup_err
);
  logic [DATAWIDTH-1:0] cap_q [NUM_NEURONS];
  logic [DATAWIDTH-1:0] cap_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] done_q, done_d;
  // a strobe loads its neuron's result and marks it done; clr empties the mask at frame end
  always_comb begin
    for (int j = 0; j < NUM_NEURONS; j++)
      cap_d[j] = nrn_out_valid[j] ? nrn_out[j*DATAWIDTH +: DATAWIDTH] : cap_q[j];
    done_d = clr ? '0 : done_q | nrn_out_valid;
  end
  // same-cycle strobes count towards completion so the drain can start one cycle later
  assign all_done = &(done_q | nrn_out_valid);
  assign dup_err = |(done_q & nrn_out_valid);
  assign rd_data = cap_q[rd_idx];
  // capture registers and done mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NUM_NEURONS; j++) cap_q[j] <= '0;
      done_q <= '0;
    end else begin
      cap_q <= cap_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: feeds one frame to a neuron layer, collects results, streams them out
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_INPUTS = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATAWIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATAWIDTH-1:0]             in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATAWIDTH-1:0]             nrn_input_val,
  output logic                             nrn_input_valid,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]           nrn_out_valid,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             err
);
  localparam int IW = cnt_w(NUM_INPUTS);
  localparam int NW = cnt_w(NUM_NEURONS);
  localparam logic [IW-1:0] IN_LAST = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] NRN_LAST = NW'(NUM_NEURONS - 1);
  state_t state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [NW-1:0] drn_cnt_q, drn_cnt_d;
  logic [DATAWIDTH-1:0] bc_val_q, bc_val_d;
  logic bc_vld_q, bc_vld_d, err_q, err_d;
  logic in_acc, drn_acc, drn_end, all_done, dup_err;
  logic [NUM_NEURONS-1:0] vld_g;
  assign in_ready = rst && state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign out_last = out_valid && drn_cnt_q == NRN_LAST;
  assign busy = state_q != LOAD;
  assign err = err_q;
  assign nrn_input_val = bc_val_q;
  assign nrn_input_valid = bc_vld_q;
  assign in_acc = in_valid && in_ready;
  assign drn_acc = out_valid && out_ready;
  assign drn_end = drn_acc && out_last;
  // results arriving while draining must not disturb the words being sent
  assign vld_g = (state_q == DRAIN) ? '0 : nrn_out_valid;
  layer_capture_bank #(.NUM_NEURONS(NUM_NEURONS), .DATAWIDTH(DATAWIDTH)) u_bank (
    .clk(clk), .rst(rst), .nrn_out(nrn_out), .nrn_out_valid(vld_g), .clr(drn_end),
    .rd_idx(drn_cnt_q), .rd_data(out_data), .all_done(all_done), .dup_err(dup_err)
  );
  // next-state: frame load, result wait, drain; counters saturate and clear at frame end
  always_comb begin
    state_d = (state_q == LOAD && in_acc && in_cnt_q == IN_LAST) ? WAIT :
              (state_q == WAIT && all_done) ? DRAIN :
              drn_end ? LOAD : state_q;
    in_cnt_d = drn_end ? '0 : (in_acc && in_cnt_q != IN_LAST) ? in_cnt_q + 1'b1 : in_cnt_q;
    drn_cnt_d = drn_end ? '0 : drn_acc ? drn_cnt_q + 1'b1 : drn_cnt_q;
    bc_vld_d = in_acc;
    bc_val_d = in_acc ? in_data : bc_val_q;
    err_d = err_q || dup_err || (state_q == DRAIN && |nrn_out_valid);
  end
  // state, counters, broadcast register and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      in_cnt_q <= '0;
      drn_cnt_q <= '0;
      bc_val_q <= '0;
      bc_vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      bc_val_q <= bc_val_d;
      bc_vld_q <= bc_vld_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of load, wait, drain, stalls, reset and error flagging
module tb_layer_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [15:0] nrn_input_val;
  logic nrn_input_valid;
  logic [47:0] nrn_out;
  logic [2:0] nrn_out_valid;
  logic [15:0] out_data;
  logic out_valid, out_last, out_ready, busy, err;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [15:0] acc [3];
  logic [15:0] bias [3];

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_INPUTS(4), .NUM_NEURONS(3), .DATAWIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nrn_input_val(nrn_input_val), .nrn_input_valid(nrn_input_valid),
    .nrn_out(nrn_out), .nrn_out_valid(nrn_out_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  // neuron models: weight 1, accumulator restarts after reporting its result
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++) acc[j] <= '0;
    end else begin
      for (int j = 0; j < 3; j++)
        if (nrn_out_valid[j]) acc[j] <= '0;
        else if (nrn_input_valid) acc[j] <= acc[j] + nrn_input_val;
    end
  end
  assign nrn_out = {acc[2] + bias[2], acc[1] + bias[1], acc[0] + bias[0]};

  always @(posedge clk) pulses <= pulses + int'(nrn_input_valid);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    chk("in_ready_before_beat", in_ready, 1);
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bc_valid", nrn_input_valid, 1);
    chk("bc_val", nrn_input_val, d);
    repeat (gap) begin
      @(negedge clk);
      chk("bc_gap", nrn_input_valid, 0);
    end
  endtask

  task automatic frame(input logic [15:0] a, b, c, d, input int gap);
    send(a, gap);
    send(b, gap);
    send(c, gap);
    send(d, 0);
    chk("in_ready_after_last", in_ready, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic strobe_all();
    repeat (2) @(negedge clk);
    chk("no_out_before_done", out_valid, 0);
    nrn_out_valid = 3'b111;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("out_valid_1_after_done", out_valid, 1);
  endtask

  task automatic drain(input logic [15:0] e0, e1, e2, input int stall_word);
    logic [15:0] e [3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("out_valid_wait", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == stall_word) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, e[i]);
          chk("stall_last", out_last, (i == 2));
          chk("stall_in_ready", in_ready, 0);
        end
      end
      out_ready = 1'b1;
      chk("out_data", out_data, e[i]);
      chk("out_last", out_last, (i == 2));
      chk("drain_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("in_ready_after_drain", in_ready, 1);
    chk("out_valid_after_drain", out_valid, 0);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    nrn_out_valid = '0;
    out_ready = 1'b0;
    bias = '{16'd0, 16'd0, 16'd0};
    repeat (2) @(negedge clk);
    chk("rst_bc_valid", nrn_input_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // 1: back-to-back frame, sum 10 on every neuron
    frame(1, 2, 3, 4, 0);
    strobe_all();
    drain(10, 10, 10, -1);
    chk("t1_err", err, 0);

    // 2: gapped input, gaps visible on the broadcast
    p0 = pulses;
    frame(1, 2, 3, 4, 2);
    strobe_all();
    chk("t2_pulses", pulses - p0, 4);
    drain(10, 10, 10, -1);

    // 3: staggered strobes 5/9/7 cycles after last beat, distinct biases show order
    bias = '{16'd0, 16'd100, 16'd200};
    frame(1, 2, 3, 4, 0);
    repeat (4) @(negedge clk);
    nrn_out_valid = 3'b001;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    @(negedge clk);
    nrn_out_valid = 3'b100;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    @(negedge clk);
    nrn_out_valid = 3'b010;
    chk("t3_wait_before_last", out_valid, 0);
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("t3_valid_after_last", out_valid, 1);
    drain(10, 110, 210, -1);
    bias = '{16'd0, 16'd0, 16'd0};

    // 4: downstream stall on the middle word
    frame(1, 2, 3, 4, 0);
    strobe_all();
    drain(10, 10, 10, 1);

    // 5: reset mid-frame, then a clean frame
    send(1, 0);
    send(2, 0);
    rst = 1'b0;
    #1;
    chk("t5_bc_valid", nrn_input_valid, 0);
    chk("t5_bc_val", nrn_input_val, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1);
    frame(5, 6, 7, 8, 0);
    strobe_all();
    drain(26, 26, 26, -1);

    // 6: duplicate strobe in WAIT and stray strobes in DRAIN
    frame(1, 2, 3, 4, 0);
    repeat (2) @(negedge clk);
    nrn_out_valid = 3'b010;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("t6_err_clean", err, 0);
    nrn_out_valid = 3'b010;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("t6_err_dup", err, 1);
    chk("t6_no_drain_yet", out_valid, 0);
    nrn_out_valid = 3'b101;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("t6_drain_start", out_valid, 1);
    nrn_out_valid = 3'b111;
    @(negedge clk);
    nrn_out_valid = 3'b000;
    chk("t6_word0_kept", out_data, 10);
    chk("t6_err_drain", err, 1);
    drain(10, 0, 10, -1);
    chk("t6_err_sticky", err, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_err_cleared", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
